ghost_mode_ctrl: RTL and testbench

Global ghost behaviour sequencer. Counts 60 Hz `frame_tick`s through the arcade scatter/chase schedule and the frightened interval, and drives the `isScatter`/`isChase` mode inputs shared by every ghost mover (Blinky and siblings). It also drives `isFrightened`, `frightFlash` and a one-cycle `modeChange` reversal pulse. It sits between the PacMan.v game-state logic (start, death, power-pellet events) and the ghost movement modules.

---
 rtl/ghost_mode_pkg.sv | 42 ++++
 rtl/ghost_fright_timer.sv | 47 ++++
 rtl/ghost_mode_ctrl.sv | 154 +++++++++++++++
 tb/tb_ghost_mode_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/ghost_mode_pkg.sv
// Shared types and default timing for the ghost scatter/chase/fright sequencer.
// Frame counts assume a 60 Hz frame_tick.
package ghost_mode_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCATTER,
        ST_CHASE,
        ST_FRIGHT
    } ghostState_t;

    localparam int FRAME_RATE_HZ = 60;

    localparam int DEF_SCAT0_FRAMES  = 7 * FRAME_RATE_HZ;
    localparam int DEF_CHASE0_FRAMES = 20 * FRAME_RATE_HZ;
    localparam int DEF_SCAT1_FRAMES  = 7 * FRAME_RATE_HZ;
    localparam int DEF_CHASE1_FRAMES = 20 * FRAME_RATE_HZ;
    localparam int DEF_SCAT2_FRAMES  = 5 * FRAME_RATE_HZ;
    localparam int DEF_CHASE2_FRAMES = 20 * FRAME_RATE_HZ;
    localparam int DEF_SCAT3_FRAMES  = 5 * FRAME_RATE_HZ;
    localparam int DEF_FRIGHT_FRAMES = 6 * FRAME_RATE_HZ;
    localparam int DEF_FLASH_FRAMES  = 2 * FRAME_RATE_HZ;

    // Phase 7 is the endless final chase, so it has no duration to load.
    function automatic logic [11:0] phaseDuration(
        input logic [2:0] ph,
        input int s0, input int c0, input int s1, input int c1,
        input int s2, input int c2, input int s3
    );
        case (ph)
            3'd0:    phaseDuration = 12'(s0);
            3'd1:    phaseDuration = 12'(c0);
            3'd2:    phaseDuration = 12'(s1);
            3'd3:    phaseDuration = 12'(c1);
            3'd4:    phaseDuration = 12'(s2);
            3'd5:    phaseDuration = 12'(c2);
            3'd6:    phaseDuration = 12'(s3);
            default: phaseDuration = 12'd0;
        endcase
    endfunction

endpackage

// File: rtl/ghost_fright_timer.sv
// Loadable 12-bit fright down-counter; flags expiry on the last tick and
// a registered flash flag once the remaining count reaches FLASH_FRAMES.
module ghost_fright_timer
    import ghost_mode_pkg::*;
#(
    parameter int FRIGHT_FRAMES = DEF_FRIGHT_FRAMES,
    parameter int FLASH_FRAMES  = DEF_FLASH_FRAMES
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_load,
    input  logic i_en,
    output logic o_expire,
    output logic o_flash
);

    localparam logic [11:0] LOAD_VAL   = 12'(FRIGHT_FRAMES);
    localparam logic [11:0] FLASH_VAL  = 12'(FLASH_FRAMES);
    localparam logic        LOAD_FLASH = (LOAD_VAL <= FLASH_VAL);

    logic [11:0] r_count;
    logic        r_flash;

    // Flash is computed from the next count so it stays aligned with the count register.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_count <= 12'd0;
            r_flash <= 1'b0;
        end else if (i_load) begin
            r_count <= LOAD_VAL;
            r_flash <= LOAD_FLASH;
        end else if (i_en) begin
            if (r_count == 12'd1) begin
                r_count <= 12'd0;
                r_flash <= 1'b0;
            end else begin
                r_count <= r_count - 12'd1;
                r_flash <= ((r_count - 12'd1) <= FLASH_VAL);
            end
        end
    end

    assign o_expire = i_en && (r_count == 12'd1);
    assign o_flash  = r_flash;

endmodule

// File: rtl/ghost_mode_ctrl.sv
// Global ghost mode sequencer: scatter/chase schedule plus optional fright.
// Fright support is compiled in only when GHOST_MODE_FRIGHT_EN is defined.
module ghost_mode_ctrl
    import ghost_mode_pkg::*;
#(
    parameter int SCAT0_FRAMES  = DEF_SCAT0_FRAMES,
    parameter int CHASE0_FRAMES = DEF_CHASE0_FRAMES,
    parameter int SCAT1_FRAMES  = DEF_SCAT1_FRAMES,
    parameter int CHASE1_FRAMES = DEF_CHASE1_FRAMES,
    parameter int SCAT2_FRAMES  = DEF_SCAT2_FRAMES,
    parameter int CHASE2_FRAMES = DEF_CHASE2_FRAMES,
    parameter int SCAT3_FRAMES  = DEF_SCAT3_FRAMES,
    parameter int FRIGHT_FRAMES = DEF_FRIGHT_FRAMES,
    parameter int FLASH_FRAMES  = DEF_FLASH_FRAMES
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_frame_tick,
    input  logic       i_pause,
    input  logic       i_game_start,
    input  logic       i_pacman_dead,
    input  logic       i_power_pellet,
    output logic       o_isScatter,
    output logic       o_isChase,
    output logic       o_isFrightened,
    output logic       o_frightFlash,
    output logic       o_modeChange,
    output logic [2:0] o_phase
);

    ghostState_t r_state;
    logic [11:0] r_schedT;
    logic [2:0]  r_phase;
    logic        r_isScatter;
    logic        r_isChase;
    logic        r_isFright;
    logic        r_modeChange;

    logic        w_tick;
    logic        w_pellet;
    logic        w_expire;
    logic [2:0]  w_nextPhase;
    logic [11:0] w_nextDur;

    assign w_tick      = i_frame_tick && !i_pause;
    assign w_nextPhase = r_phase + 3'd1;
    assign w_nextDur   = phaseDuration(w_nextPhase, SCAT0_FRAMES, CHASE0_FRAMES, SCAT1_FRAMES,
                                       CHASE1_FRAMES, SCAT2_FRAMES, CHASE2_FRAMES, SCAT3_FRAMES);

`ifdef GHOST_MODE_FRIGHT_EN
    logic r_retChase;
    logic w_flash;
    logic w_frLoad;
    logic w_frEn;

    // A pellet consumes any same-cycle tick, so the timer only counts pellet-free ticks.
    assign w_pellet = i_power_pellet;
    assign w_frLoad = i_power_pellet && !i_pacman_dead && (r_state != ST_IDLE);
    assign w_frEn   = w_tick && (r_state == ST_FRIGHT) && !i_power_pellet && !i_pacman_dead;

    ghost_fright_timer #(
        .FRIGHT_FRAMES (FRIGHT_FRAMES),
        .FLASH_FRAMES  (FLASH_FRAMES)
    ) u_frightTimer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clear  (i_pacman_dead),
        .i_load   (w_frLoad),
        .i_en     (w_frEn),
        .o_expire (w_expire),
        .o_flash  (w_flash)
    );

    assign o_frightFlash = w_flash;
`else
    logic w_unusedPellet;
    localparam int unusedFrightCfg = FRIGHT_FRAMES + FLASH_FRAMES;

    assign w_unusedPellet = i_power_pellet;
    assign w_pellet       = 1'b0;
    assign w_expire       = 1'b0;
    assign o_frightFlash  = 1'b0;
`endif

    // Death shares the reset path: back to idle with phase and schedule cleared.
    always_ff @(posedge i_clk) begin
        r_modeChange <= 1'b0;
        if (i_rst || i_pacman_dead) begin
            r_state     <= ST_IDLE;
            r_phase     <= 3'd0;
            r_schedT    <= 12'd0;
            r_isScatter <= 1'b0;
            r_isChase   <= 1'b0;
            r_isFright  <= 1'b0;
`ifdef GHOST_MODE_FRIGHT_EN
            r_retChase  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_game_start) begin
                        r_state     <= ST_SCATTER;
                        r_phase     <= 3'd0;
                        r_schedT    <= 12'(SCAT0_FRAMES);
                        r_isScatter <= 1'b1;
                    end
                end
                ST_SCATTER, ST_CHASE: begin
                    if (w_pellet) begin
`ifdef GHOST_MODE_FRIGHT_EN
                        r_retChase <= (r_state == ST_CHASE);
`endif
                        r_state      <= ST_FRIGHT;
                        r_isScatter  <= 1'b0;
                        r_isChase    <= 1'b0;
                        r_isFright   <= 1'b1;
                        r_modeChange <= 1'b1;
                    end else if (w_tick && (r_phase != 3'd7)) begin
                        if (r_schedT == 12'd1) begin
                            r_phase      <= w_nextPhase;
                            r_schedT     <= w_nextDur;
                            r_modeChange <= 1'b1;
                            r_state      <= (r_state == ST_SCATTER) ? ST_CHASE : ST_SCATTER;
                            r_isScatter  <= (r_state == ST_CHASE);
                            r_isChase    <= (r_state == ST_SCATTER);
                        end else begin
                            r_schedT <= r_schedT - 12'd1;
                        end
                    end
                end
`ifdef GHOST_MODE_FRIGHT_EN
                ST_FRIGHT: begin
                    if (w_expire) begin
                        r_state     <= r_retChase ? ST_CHASE : ST_SCATTER;
                        r_isScatter <= !r_retChase;
                        r_isChase   <= r_retChase;
                        r_isFright  <= 1'b0;
                    end
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_isScatter    = r_isScatter;
    assign o_isChase      = r_isChase;
    assign o_isFrightened = r_isFright;
    assign o_modeChange   = r_modeChange;
    assign o_phase        = r_phase;

endmodule

// File: tb/tb_ghost_mode_ctrl.sv
// Randomized bench for ghost_mode_ctrl against a tick-counting reference model.
// Honours GHOST_MODE_FRIGHT_EN the same way the design does.
module tb_ghost_mode_ctrl;

`ifdef GHOST_MODE_FRIGHT_EN
    localparam bit FRIGHT_EN = 1'b1;
`else
    localparam bit FRIGHT_EN = 1'b0;
`endif

    localparam int FRIGHT_LEN = 360;
    localparam int FLASH_LEN  = 120;
    int phaseLen [7] = '{420, 1200, 420, 1200, 300, 1200, 300};

    logic       clk = 1'b0;
    logic       rst, frameTick, pause, gameStart, pacmanDead, powerPellet;
    logic       isScatter, isChase, isFrightened, frightFlash, modeChange;
    logic [2:0] phase;

    always #5 clk = ~clk;

    ghost_mode_ctrl dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_frame_tick   (frameTick),
        .i_pause        (pause),
        .i_game_start   (gameStart),
        .i_pacman_dead  (pacmanDead),
        .i_power_pellet (powerPellet),
        .o_isScatter    (isScatter),
        .o_isChase      (isChase),
        .o_isFrightened (isFrightened),
        .o_frightFlash  (frightFlash),
        .o_modeChange   (modeChange),
        .o_phase        (phase)
    );

    // Model: mode 0 idle, 1 scatter, 2 chase, 3 fright; counts ticks elapsed upward.
    int mMode = 0, mPhase = 0, mElapsed = 0, mFrElapsed = 0;
    bit mRetChase = 1'b0, mModeChange = 1'b0;
    int errors = 0, checks = 0, effTicks = 0, pelletEvery = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic void modelStep();
        bit eff = frameTick && !pause;
        mModeChange = 1'b0;
        if (rst || pacmanDead) begin
            mMode = 0; mPhase = 0; mElapsed = 0; mFrElapsed = 0;
        end else if (mMode == 0) begin
            if (gameStart) begin mMode = 1; mPhase = 0; mElapsed = 0; end
        end else if (mMode == 1 || mMode == 2) begin
            if (powerPellet && FRIGHT_EN) begin
                mRetChase = (mMode == 2); mMode = 3; mFrElapsed = 0; mModeChange = 1'b1;
            end else if (eff && mPhase < 7) begin
                mElapsed++;
                if (mElapsed == phaseLen[mPhase]) begin
                    mPhase++; mElapsed = 0; mMode = 3 - mMode; mModeChange = 1'b1;
                end
            end
        end else begin
            if (powerPellet) mFrElapsed = 0;
            else if (eff) begin
                mFrElapsed++;
                if (mFrElapsed == FRIGHT_LEN) mMode = mRetChase ? 2 : 1;
            end
        end
    endfunction

    task automatic applyStimulus(input bit tick, input bit p, input bit start, input bit dead,
                                 input bit pellet, input bit r);
        @(negedge clk);
        frameTick = tick; pause = p; gameStart = start;
        pacmanDead = dead; powerPellet = pellet; rst = r;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput("isScatter", isScatter, (mMode == 1));
        checkOutput("isChase", isChase, (mMode == 2));
        checkOutput("isFrightened", isFrightened, (mMode == 3));
        checkOutput("frightFlash", frightFlash, (mMode == 3) && (FRIGHT_LEN - mFrElapsed <= FLASH_LEN));
        checkOutput("modeChange", modeChange, mModeChange);
        checkOutput("phase", phase, mPhase);
    endtask

    // Issues n effective ticks separated by random idle and paused cycles.
    task automatic doTicks(input int n);
        int got = 0, cyc = 0;
        while (got < n && cyc < n * 16 + 64) begin
            bit t   = ($urandom_range(0, 3) != 0);
            bit p   = ($urandom_range(0, 15) == 0);
            bit eff = t && !p;
            bit pel = eff && (pelletEvery > 0) && ((effTicks + 1) % pelletEvery == 0);
            applyStimulus(t, p, 1'b0, 1'b0, pel, 1'b0);
            if (eff) begin got++; effTicks++; end
            cyc++;
        end
        checkOutput("tick_budget", got, n);
    endtask

    initial begin
        {rst, frameTick, pause, gameStart, pacmanDead, powerPellet} = '0;
        pelletEvery = FRIGHT_EN ? 0 : 10;

        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 1, 0, 1, 1);
        checkOutput("reset_phase", phase, 0);
        checkOutput("reset_scat", isScatter, 0);

        // First scatter phase lasts exactly 420 ticks.
        applyStimulus(1, 0, 1, 0, 0, 0);
        checkOutput("start_scat", isScatter, 1);
        doTicks(419);
        checkOutput("t419_scat", isScatter, 1);
        checkOutput("t419_chase", isChase, 0);
        doTicks(1);
        checkOutput("t420_chase", isChase, 1);
        checkOutput("t420_phase", phase, 1);
        checkOutput("t420_mc", modeChange, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t420_mc_drop", modeChange, 0);
        pelletEvery = 0;

        if (FRIGHT_EN) begin
            doTicks(700);
            applyStimulus(1, 0, 0, 0, 1, 0);
            checkOutput("fr_enter", isFrightened, 1);
            checkOutput("fr_enter_mc", modeChange, 1);
            doTicks(239);
            checkOutput("fr_239_flash", frightFlash, 0);
            doTicks(1);
            checkOutput("fr_240_flash", frightFlash, 1);
            doTicks(120);
            checkOutput("fr_exit_chase", isChase, 1);
            checkOutput("fr_exit_mc", modeChange, 0);
            doTicks(499);
            checkOutput("resume_chase", isChase, 1);
            doTicks(1);
            checkOutput("resume_scat", isScatter, 1);
            checkOutput("resume_phase", phase, 2);
            applyStimulus(0, 0, 0, 0, 1, 0);
            doTicks(310);
            checkOutput("fr50_flash", frightFlash, 1);
            applyStimulus(0, 0, 0, 0, 1, 0);
            checkOutput("repellet_flash", frightFlash, 0);
            checkOutput("repellet_mc", modeChange, 0);
            for (int i = 0; i < 100; i++) applyStimulus(1, 1, 0, 0, 0, 0);
            doTicks(359);
            checkOutput("refr_still", isFrightened, 1);
            doTicks(1);
            checkOutput("refr_exit_scat", isScatter, 1);
        end

        for (int i = 0; i < 3000 && !isChase; i++) doTicks(1);
        checkOutput("reach_chase", isChase, 1);
        applyStimulus(1, 0, 0, 1, 1, 0);
        checkOutput("dead_chase", isChase, 0);
        checkOutput("dead_fright", isFrightened, 0);
        checkOutput("dead_phase", phase, 0);
        applyStimulus(1, 0, 1, 0, 0, 0);
        checkOutput("restart_scat", isScatter, 1);
        checkOutput("restart_phase", phase, 0);

        // Whole schedule, then the endless final chase.
        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 1, 0, 0, 0);
        doTicks(5040);
        checkOutput("sched_phase7", phase, 7);
        checkOutput("sched_chase7", isChase, 1);
        doTicks(10000);
        checkOutput("final_phase7", phase, 7);
        checkOutput("final_chase7", isChase, 1);

        for (int i = 0; i < 12000; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                          $urandom_range(0, 149) == 0, $urandom_range(0, 2499) == 0,
                          $urandom_range(0, 399) == 0, $urandom_range(0, 4999) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
